instr_rom_loadable: RTL and testbench
=====================================

Name: instr_rom_loadable

Overview:
- Parametrised, registered instruction memory for the MIPS single-cycle/pipelined CPU. Replaces the fixed combinational program ROM.
- Serves instruction fetches with a 1-cycle read latency.
- Supports in-system reprogramming through a byte-serial load port, driven by the UART receiver or a bench.
- Out-of-range and not-ready fetches return a jump-to-reset word, so the CPU always re-enters at 0x00000000.

Parameters:
- ADDR_WIDTH, 8, word-address bits; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, instruction width; must be a multiple of 8.
- DEFAULT_WORD, 32'h08000000, word returned for out-of-range, loading or blocked fetches (j 0).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_en  in  1  fetch request this cycle.
- fetch_addr  in  32  byte address (PC).
- fetch_data  out  DATA_WIDTH  instruction, registered.
- fetch_valid  out  1  fetch_data is the result of the previous cycle's fetch_en.
- load_start  in  1  one-cycle pulse; begins a load (ignored unless IDLE).
- load_byte_valid  in  1  load_byte is valid this cycle.
- load_byte  in  8  serial program byte.
- load_busy  out  1  high in HDR/DATA states.
- load_done  out  1  one-cycle pulse when a load completes successfully.
- load_err  out  1  sticky; set on oversize header; cleared by load_start or reset.

Behaviour:
- Reset (async, active-high):
  - Outputs: fetch_data=DEFAULT_WORD, fetch_valid=0, load_busy=0, load_done=0, load_err=0.
  - FSM -> IDLE; byte/word counters cleared.
  - Memory array is NOT cleared by reset. Its initial content at configuration is DEFAULT_WORD in every word.
- Address decode:
  - Word index = fetch_addr[ADDR_WIDTH+1:2].
  - fetch_addr[31] is ignored (kernel-mode PC bit); fetch_addr[1:0] are ignored.
  - In range iff fetch_addr[30:ADDR_WIDTH+2] == 0. Otherwise the fetch returns DEFAULT_WORD.
- Fetch:
  - fetch_en high at edge t -> fetch_data and fetch_valid=1 visible after edge t+1.
  - fetch_en low -> fetch_valid=0 next cycle; fetch_data holds its last value.
  - Back-to-back fetches are allowed every cycle.
- FSM states:
  - IDLE: fetches served from memory. load_start -> HDR; clears load_err, byte counter and word count.
  - HDR: takes 2 bytes (big-endian) forming word count N[15:0].
    - N == 0 -> IDLE, pulse load_done.
    - N > 2**ADDR_WIDTH -> IDLE, set load_err, no writes.
    - Otherwise -> DATA.
  - DATA: assembles DATA_WIDTH/8 bytes per word, MSB first.
    - On the last byte of each word, write to index w (starting at 0), then w++.
    - After word N-1 is written -> IDLE, pulse load_done in the following cycle.
- Fetches during HDR/DATA:
  - fetch_valid follows fetch_en as usual.
  - fetch_data = DEFAULT_WORD; memory is not read.
- Byte handling:
  - load_byte_valid is ignored in IDLE.
  - load_start is ignored in HDR/DATA.
  - Words at index >= N keep their previous contents.
- Simultaneous events:
  - A write and a fetch in the same cycle cannot conflict, because fetches are blocked while loading.
  - load_start and fetch_en in the same IDLE cycle: the fetch is served from memory; the FSM moves to HDR.
- Reset mid-load:
  - FSM -> IDLE; any partial word is discarded; no load_done.
  - Already-written words remain in memory.

Test Plan:
- Power-up, no load: fetch 0x00000000, 0x80000004 and 0x000003FC -> DEFAULT_WORD 0x08000000, fetch_valid=1 one cycle after each fetch_en. fetch 0x00000400 (ADDR_WIDTH=8) -> 0x08000000.
- Load N=3:
  - Bytes 00 03 | 20 08 00 40 | AC 08 00 00 | 03 E0 00 08.
  - Expect load_busy high throughout and a load_done pulse.
  - Then fetch 0x0, 0x4, 0x8 -> 0x20080040, 0xAC080000, 0x03E00008; fetch 0xC -> 0x08000000.
- Kernel alias and misalignment: after the load above, fetch 0x80000004 and 0x00000006 -> 0xAC080000.
- Oversize header: bytes 01 01 (N=257, ADDR_WIDTH=8) -> load_err=1, no load_done, previous contents unchanged; the next load_start clears load_err.
- Fetch during load: fetch_en every cycle while in DATA -> fetch_valid=1 and fetch_data=0x08000000 throughout.
- Reset mid-load: assert reset after 6 data bytes of N=2 -> word 0 written, word 1 unchanged, FSM IDLE, load_busy=0, no load_done.

Source files
------------

// File: rtl/instr_rom_loadable.sv
// Registered instruction memory with a 1-cycle fetch latency and a byte-serial loader.
// Header is 2 bytes (big-endian word count) and is followed by the words, MSB first.
module instr_rom_loadable #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = DATA_WIDTH'(32'h08000000)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_en,
  input  logic [31:0]           fetch_addr,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic                  fetch_valid,
  input  logic                  load_start,
  input  logic                  load_byte_valid,
  input  logic [7:0]            load_byte,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_err,
  output logic [1:0]            dbg_state
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CW    = 17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // Load port handshake: valid-only, no back-pressure. A byte is consumed on
  // every rising edge where load_byte_valid is high and the FSM is in HDR/DATA.

  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: DEFAULT_WORD};

  state_t                state_q, state_d;
  logic                  hdr_phase_q, hdr_phase_d;
  logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [15:0]           n_q, n_d;
  logic [ADDR_WIDTH:0]   word_idx_q, word_idx_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic                  load_done_q, load_done_d;
  logic                  load_err_q, load_err_d;
  logic [DATA_WIDTH-1:0] fetch_data_q, fetch_data_d;
  logic                  fetch_valid_q, fetch_valid_d;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] asm_shift;
  logic [15:0]           hdr_n;
  logic [30:0]           hi_bits;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  unused_addr_bits;

  assign asm_shift = (asm_q << 8) | DATA_WIDTH'(load_byte);

  // Bit 31 is the kernel-mode alias and bits 1:0 are byte offsets; neither selects a word.
  assign unused_addr_bits = ^{fetch_addr[31], fetch_addr[1:0]};
  assign hi_bits  = fetch_addr[30:0] >> (ADDR_WIDTH + 2);
  assign in_range = (hi_bits == '0);
  assign rd_idx   = fetch_addr[ADDR_WIDTH+1:2];

  always_comb begin
    state_d     = state_q;
    hdr_phase_d = hdr_phase_q;
    byte_cnt_d  = byte_cnt_q;
    n_d         = n_q;
    word_idx_d  = word_idx_q;
    asm_d       = asm_q;
    load_done_d = 1'b0;
    load_err_d  = load_err_q;
    hdr_n       = {n_q[7:0], load_byte};
    mem_we      = 1'b0;
    mem_waddr   = word_idx_q[ADDR_WIDTH-1:0];
    mem_wdata   = asm_shift;

    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d     = ST_HDR;
          load_err_d  = 1'b0;
          hdr_phase_d = 1'b0;
          byte_cnt_d  = '0;
          word_idx_d  = '0;
          n_d         = '0;
        end
      end
      ST_HDR: begin
        if (load_byte_valid) begin
          if (!hdr_phase_q) begin
            n_d         = {8'h00, load_byte};
            hdr_phase_d = 1'b1;
          end else begin
            n_d         = hdr_n;
            hdr_phase_d = 1'b0;
            if (hdr_n == 16'd0) begin
              state_d     = ST_IDLE;
              load_done_d = 1'b1;
            end else if ({1'b0, hdr_n} > CW'(DEPTH)) begin
              // Oversize images are rejected before any word is touched.
              state_d    = ST_IDLE;
              load_err_d = 1'b1;
            end else begin
              state_d    = ST_DATA;
              byte_cnt_d = '0;
              word_idx_d = '0;
            end
          end
        end
      end
      ST_DATA: begin
        if (load_byte_valid) begin
          asm_d = asm_shift;
          if (byte_cnt_q == BCW'(BYTES - 1)) begin
            mem_we     = 1'b1;
            byte_cnt_d = '0;
            word_idx_d = word_idx_q + 1'b1;
            if (CW'(word_idx_q) + CW'(1) == {1'b0, n_q}) begin
              state_d     = ST_IDLE;
              load_done_d = 1'b1;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory is only read while idle, so a load write never races a fetch.
  always_comb begin
    fetch_valid_d = fetch_en;
    fetch_data_d  = fetch_data_q;
    if (fetch_en) begin
      if (state_q == ST_IDLE && in_range) begin
        fetch_data_d = mem[rd_idx];
      end else begin
        fetch_data_d = DEFAULT_WORD;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      hdr_phase_q   <= 1'b0;
      byte_cnt_q    <= '0;
      n_q           <= '0;
      word_idx_q    <= '0;
      asm_q         <= '0;
      load_done_q   <= 1'b0;
      load_err_q    <= 1'b0;
      fetch_data_q  <= DEFAULT_WORD;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hdr_phase_q   <= hdr_phase_d;
      byte_cnt_q    <= byte_cnt_d;
      n_q           <= n_d;
      word_idx_q    <= word_idx_d;
      asm_q         <= asm_d;
      load_done_q   <= load_done_d;
      load_err_q    <= load_err_d;
      fetch_data_q  <= fetch_data_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  // Contents survive reset; only the configuration-time initialiser sets them.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign fetch_data  = fetch_data_q;
  assign fetch_valid = fetch_valid_q;
  assign load_busy   = (state_q != ST_IDLE);
  assign load_done   = load_done_q;
  assign load_err    = load_err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_rom_loadable.sv
// Bench for instr_rom_loadable: fetch scoreboard, serial loads, oversize header and reset mid-load.
module tb_instr_rom_loadable;

  localparam logic [31:0] DEF = 32'h08000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_data;
  logic        fetch_valid;
  logic        load_start;
  logic        load_byte_valid;
  logic [7:0]  load_byte;
  logic        load_busy;
  logic        load_done;
  logic        load_err;
  logic [1:0]  dbg_state;

  logic [31:0] mem_m [256];
  logic [31:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  instr_rom_loadable #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEFAULT_WORD(DEF)) dut (
    .clk(clk), .reset(reset),
    .fetch_en(fetch_en), .fetch_addr(fetch_addr),
    .fetch_data(fetch_data), .fetch_valid(fetch_valid),
    .load_start(load_start), .load_byte_valid(load_byte_valid), .load_byte(load_byte),
    .load_busy(load_busy), .load_done(load_done), .load_err(load_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_done === 1'b1) done_cnt++;
  end

  function automatic logic [31:0] model_fetch(input logic [31:0] a, input logic loading);
    if (loading || (a[30:10] != 21'd0)) return DEF;
    return mem_m[a[9:2]];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    load_byte_valid = 1'b1;
    load_byte       = b;
    tick();
    load_byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (fetch_data !== DEF || fetch_valid !== 1'b0 || load_busy !== 1'b0 ||
        load_done !== 1'b0 || load_err !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got data=%h valid=%b busy=%b done=%b err=%b st=%0d, want data=%h others 0",
               fetch_data, fetch_valid, load_busy, load_done, load_err, dbg_state, DEF);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_powerup_fetch();
    logic [31:0] addrs [4];
    logic [31:0] want;
    addrs = '{32'h0000_0000, 32'h8000_0004, 32'h0000_03FC, 32'h0000_0400};
    for (int i = 0; i < 4; i++) begin
      fetch_en   = 1'b1;
      fetch_addr = addrs[i];
      exp_q.push_back(model_fetch(addrs[i], 1'b0));
      tick();
      want = exp_q.pop_front();
      n_checks++;
      if (fetch_valid !== 1'b1 || fetch_data !== want) begin
        n_fail++;
        $display("FAIL powerup_fetch %h: got valid=%b data=%h, want valid=1 data=%h",
                 addrs[i], fetch_valid, fetch_data, want);
      end
    end
    fetch_en   = 1'b0;
    fetch_addr = 32'h0000_0008;
    tick();
    n_checks++;
    if (fetch_valid !== 1'b0 || fetch_data !== want) begin
      n_fail++;
      $display("FAIL idle_hold: got valid=%b data=%h, want valid=0 data=%h", fetch_valid, fetch_data, want);
    end
    load_byte_valid = 1'b1;
    load_byte       = 8'h55;
    tick();
    load_byte_valid = 1'b0;
    n_checks++;
    if (load_busy !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL idle_byte_ignored: got busy=%b st=%0d, want busy=0 st=0", load_busy, dbg_state);
    end
  endtask

  task automatic test_load_n3();
    logic [7:0]  bytes [14];
    logic [31:0] addrs [4];
    logic [31:0] want;
    int d0;
    bytes = '{8'h00, 8'h03, 8'h20, 8'h08, 8'h00, 8'h40, 8'hAC, 8'h08, 8'h00, 8'h00,
              8'h03, 8'hE0, 8'h00, 8'h08};
    d0 = done_cnt;
    load_start = 1'b1;
    fetch_en   = 1'b1;
    fetch_addr = 32'h0;
    exp_q.push_back(model_fetch(32'h0, 1'b0));
    tick();
    load_start = 1'b0;
    fetch_en   = 1'b0;
    want = exp_q.pop_front();
    n_checks++;
    if (fetch_valid !== 1'b1 || fetch_data !== want || load_busy !== 1'b1 || dbg_state !== 2'd1) begin
      n_fail++;
      $display("FAIL start_with_fetch: got valid=%b data=%h busy=%b st=%0d, want valid=1 data=%h busy=1 st=1",
               fetch_valid, fetch_data, load_busy, dbg_state, want);
    end
    for (int i = 0; i < 14; i++) begin
      n_checks++;
      if (load_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL n3_busy byte %0d: got busy=%b, want 1", i, load_busy);
      end
      send_byte(bytes[i]);
    end
    n_checks++;
    if (load_done !== 1'b1 || load_busy !== 1'b0 || load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL n3_done: got done=%b busy=%b err=%b, want done=1 busy=0 err=0", load_done, load_busy, load_err);
    end
    tick();
    n_checks++;
    if (load_done !== 1'b0 || done_cnt != d0 + 1) begin
      n_fail++;
      $display("FAIL n3_done_pulse: got done=%b pulses=%0d, want done=0 pulses=1", load_done, done_cnt - d0);
    end
    mem_m[0] = 32'h2008_0040;
    mem_m[1] = 32'hAC08_0000;
    mem_m[2] = 32'h03E0_0008;
    addrs = '{32'h0, 32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 4; i++) begin
      fetch_en   = 1'b1;
      fetch_addr = addrs[i];
      exp_q.push_back(model_fetch(addrs[i], 1'b0));
      tick();
      want = exp_q.pop_front();
      n_checks++;
      if (fetch_valid !== 1'b1 || fetch_data !== want) begin
        n_fail++;
        $display("FAIL n3_fetch %h: got valid=%b data=%h, want valid=1 data=%h",
                 addrs[i], fetch_valid, fetch_data, want);
      end
    end
    fetch_en = 1'b0;
    tick();
  endtask

  task automatic test_alias();
    logic [31:0] addrs [4];
    logic [31:0] want;
    addrs = '{32'h8000_0004, 32'h0000_0006, 32'h8000_03FC, 32'h7FFF_FFFC};
    for (int i = 0; i < 4; i++) begin
      fetch_en   = 1'b1;
      fetch_addr = addrs[i];
      exp_q.push_back(model_fetch(addrs[i], 1'b0));
      tick();
      want = exp_q.pop_front();
      n_checks++;
      if (fetch_valid !== 1'b1 || fetch_data !== want) begin
        n_fail++;
        $display("FAIL alias_fetch %h: got valid=%b data=%h, want valid=1 data=%h",
                 addrs[i], fetch_valid, fetch_data, want);
      end
    end
    fetch_en = 1'b0;
    tick();
  endtask

  task automatic test_oversize();
    logic [31:0] want;
    int d0;
    d0 = done_cnt;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    send_byte(8'h01);
    send_byte(8'h01);
    tick();
    n_checks++;
    if (load_err !== 1'b1 || load_busy !== 1'b0 || dbg_state !== 2'd0 || done_cnt != d0) begin
      n_fail++;
      $display("FAIL oversize: got err=%b busy=%b st=%0d pulses=%0d, want err=1 busy=0 st=0 pulses=0",
               load_err, load_busy, dbg_state, done_cnt - d0);
    end
    for (int i = 0; i < 3; i++) begin
      fetch_en   = 1'b1;
      fetch_addr = 32'(i * 4);
      exp_q.push_back(model_fetch(32'(i * 4), 1'b0));
      tick();
      want = exp_q.pop_front();
      n_checks++;
      if (fetch_valid !== 1'b1 || fetch_data !== want) begin
        n_fail++;
        $display("FAIL oversize_keep %0d: got valid=%b data=%h, want valid=1 data=%h",
                 i, fetch_valid, fetch_data, want);
      end
    end
    fetch_en   = 1'b0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    n_checks++;
    if (load_err !== 1'b0 || load_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL err_clear: got err=%b busy=%b, want err=0 busy=1", load_err, load_busy);
    end
    d0 = done_cnt;
    send_byte(8'h00);
    send_byte(8'h00);
    n_checks++;
    if (load_done !== 1'b1 || load_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_count: got done=%b busy=%b, want done=1 busy=0", load_done, load_busy);
    end
    tick();
    n_checks++;
    if (done_cnt != d0 + 1) begin
      n_fail++;
      $display("FAIL zero_count_pulse: got pulses=%0d, want 1", done_cnt - d0);
    end
  endtask

  task automatic test_fetch_during_load();
    logic [7:0]  bytes [6];
    logic [31:0] want;
    bytes = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    load_start = 1'b1;
    fetch_en   = 1'b1;
    fetch_addr = 32'h0;
    exp_q.push_back(model_fetch(32'h0, 1'b0));
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      want = exp_q.pop_front();
      n_checks++;
      if (fetch_valid !== 1'b1 || fetch_data !== want) begin
        n_fail++;
        $display("FAIL load_fetch cyc %0d: got valid=%b data=%h, want valid=1 data=%h",
                 i, fetch_valid, fetch_data, want);
      end
      fetch_addr      = 32'(i * 4);
      load_byte_valid = 1'b1;
      load_byte       = bytes[i];
      load_start      = (i == 4);
      exp_q.push_back(model_fetch(fetch_addr, 1'b1));
      tick();
    end
    load_byte_valid = 1'b0;
    load_start      = 1'b0;
    fetch_en        = 1'b0;
    want = exp_q.pop_front();
    n_checks++;
    if (fetch_valid !== 1'b1 || fetch_data !== want || load_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL load_fetch_last: got valid=%b data=%h busy=%b, want valid=1 data=%h busy=0",
               fetch_valid, fetch_data, load_busy, want);
    end
    mem_m[0] = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      fetch_en   = 1'b1;
      fetch_addr = 32'(i * 4);
      exp_q.push_back(model_fetch(32'(i * 4), 1'b0));
      tick();
      want = exp_q.pop_front();
      n_checks++;
      if (fetch_valid !== 1'b1 || fetch_data !== want) begin
        n_fail++;
        $display("FAIL after_load_fetch %0d: got valid=%b data=%h, want valid=1 data=%h",
                 i, fetch_valid, fetch_data, want);
      end
    end
    fetch_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_load();
    logic [7:0]  bytes [8];
    logic [31:0] want;
    int d0;
    bytes = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    d0 = done_cnt;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(bytes[i]);
    reset = 1'b1;
    #1;
    n_checks++;
    if (load_busy !== 1'b0 || dbg_state !== 2'd0 || load_done !== 1'b0 ||
        fetch_valid !== 1'b0 || fetch_data !== DEF) begin
      n_fail++;
      $display("FAIL mid_reset: got busy=%b st=%0d done=%b valid=%b data=%h, want 0/0/0/0/%h",
               load_busy, dbg_state, load_done, fetch_valid, fetch_data, DEF);
    end
    tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if (done_cnt != d0 || load_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_nodone: got pulses=%0d busy=%b, want pulses=0 busy=0", done_cnt - d0, load_busy);
    end
    mem_m[0] = 32'h1122_3344;
    for (int i = 0; i < 2; i++) begin
      fetch_en   = 1'b1;
      fetch_addr = 32'(i * 4);
      exp_q.push_back(model_fetch(32'(i * 4), 1'b0));
      tick();
      want = exp_q.pop_front();
      n_checks++;
      if (fetch_valid !== 1'b1 || fetch_data !== want) begin
        n_fail++;
        $display("FAIL mid_reset_mem %0d: got valid=%b data=%h, want valid=1 data=%h",
                 i, fetch_valid, fetch_data, want);
      end
    end
    fetch_en = 1'b0;
    tick();
  endtask

  initial begin
    foreach (mem_m[i]) mem_m[i] = DEF;
    reset           = 1'b1;
    fetch_en        = 1'b0;
    fetch_addr      = 32'h0;
    load_start      = 1'b0;
    load_byte_valid = 1'b0;
    load_byte       = 8'h00;
    test_reset();
    test_powerup_fetch();
    test_load_n3();
    test_alias();
    test_oversize();
    test_fetch_during_load();
    test_reset_mid_load();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
